// File: rtl/timer8_apb_regs.sv
// ----------------------------------------------------------------------------
// timer8_apb_regs
// 8-bit up/down timer with a 3-bit prescaler behind a zero-wait-state APB
// register slave.
//
// Register map (byte addresses):
//   0x00 TDR  RW  reload value
//   0x01 TCR  RW  [7] load, [5] down, [4] en, [1:0] cks (/1,/2,/4,/8)
//   0x02 TSR  W1C [1] udf, [0] ovf
//   0x03 TIE  RW  [1] udf_ie, [0] ovf_ie
//   0x04 TCNT RO  current count
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   psel       APB select
//   penable    APB access phase
//   pwrite     1 = write, 0 = read
//   paddr      byte register address (ADDR_W bits)
//   pwdata     write data
//   prdata     read data, combinational from register state
//   pready     always 1
//   pslverr    always 0
//   interrupt  level interrupt, combinational from TSR & TIE
// ----------------------------------------------------------------------------
module timer8_apb_regs #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              interrupt
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PRE_W  = 3;
    localparam int unsigned FLAG_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_TDR  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_TCR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TSR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_TIE  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_TCNT = ADDR_W'(4);

    // Implemented TCR bits; reserved positions are never stored.
    localparam logic [DATA_W-1:0] TCR_MASK = 8'hB3;

    localparam logic [1:0] CKS_DIV1 = 2'b00;
    localparam logic [1:0] CKS_DIV2 = 2'b01;
    localparam logic [1:0] CKS_DIV4 = 2'b10;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] tdr_q,  tdr_d;
    logic [DATA_W-1:0] tcr_q,  tcr_d;
    logic [FLAG_W-1:0] tsr_q,  tsr_d;
    logic [FLAG_W-1:0] tie_q,  tie_d;
    logic [DATA_W-1:0] tcnt_q, tcnt_d;
    logic [PRE_W-1:0]  pre_q,  pre_d;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic wr_en;
    logic rd_en;
    logic wr_tdr;
    logic wr_tcr;
    logic wr_tsr;
    logic wr_tie;

    logic       tcr_load;
    logic       tcr_down;
    logic       tcr_en;
    logic [1:0] tcr_cks;

    // A write commits only in the access phase; setup cycles are inert.
    always_comb begin
        wr_en  = psel & penable & pwrite;
        rd_en  = psel & ~pwrite;
        wr_tdr = wr_en & (paddr == ADDR_TDR);
        wr_tcr = wr_en & (paddr == ADDR_TCR);
        wr_tsr = wr_en & (paddr == ADDR_TSR);
        wr_tie = wr_en & (paddr == ADDR_TIE);
    end

    always_comb begin
        tcr_load = tcr_q[7];
        tcr_down = tcr_q[5];
        tcr_en   = tcr_q[4];
        tcr_cks  = tcr_q[1:0];
    end

    // ------------------------------------------------------------------------
    // Prescaler and count tick
    // ------------------------------------------------------------------------
    logic cnt_run;
    logic tick;

    // Tick fires when the low cks bits of the prescaler are all ones, so the
    // first tick lands 1/2/4/8 cycles after the prescaler leaves zero.
    always_comb begin
        cnt_run = tcr_en & ~tcr_load;
        case (tcr_cks)
            CKS_DIV1: tick = cnt_run;
            CKS_DIV2: tick = cnt_run & pre_q[0];
            CKS_DIV4: tick = cnt_run & (&pre_q[1:0]);
            default:  tick = cnt_run & (&pre_q);
        endcase
    end

    // Any TCR write restarts the prescale phase.
    always_comb begin
        pre_d = pre_q;
        if (!cnt_run || wr_tcr) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------------
    logic ovf_set;
    logic udf_set;

    // Load wins over counting and never raises a flag.
    always_comb begin
        tcnt_d  = tcnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (tcr_load) begin
            tcnt_d = tdr_q;
        end else if (tick) begin
            if (tcr_down) begin
                tcnt_d  = tcnt_q - DATA_W'(1);
                udf_set = (tcnt_q == 8'h00);
            end else begin
                tcnt_d  = tcnt_q + DATA_W'(1);
                ovf_set = (tcnt_q == 8'hFF);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------------
    logic [FLAG_W-1:0] w1c_mask;

    // Hardware set is OR'd in after the clear so a coincident event survives.
    always_comb begin
        w1c_mask = wr_tsr ? pwdata[FLAG_W-1:0] : '0;
        tsr_d    = (tsr_q & ~w1c_mask) | {udf_set, ovf_set};
    end

    // ------------------------------------------------------------------------
    // Software-writable registers
    // ------------------------------------------------------------------------
    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        tie_d = tie_q;
        if (wr_tdr) begin
            tdr_d = pwdata;
        end
        if (wr_tcr) begin
            tcr_d = pwdata & TCR_MASK;
        end
        if (wr_tie) begin
            tie_d = pwdata[FLAG_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // State register; reset overrides any concurrent write or tick
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tdr_q  <= '0;
            tcr_q  <= '0;
            tsr_q  <= '0;
            tie_q  <= '0;
            tcnt_q <= '0;
            pre_q  <= '0;
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            tie_q  <= tie_d;
            tcnt_q <= tcnt_d;
            pre_q  <= pre_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read mux; unmapped addresses and non-read cycles return zero
    // ------------------------------------------------------------------------
    always_comb begin
        prdata = '0;
        if (rd_en) begin
            if (paddr == ADDR_TDR) begin
                prdata = tdr_q;
            end else if (paddr == ADDR_TCR) begin
                prdata = tcr_q;
            end else if (paddr == ADDR_TSR) begin
                prdata = {6'b000000, tsr_q};
            end else if (paddr == ADDR_TIE) begin
                prdata = {6'b000000, tie_q};
            end else if (paddr == ADDR_TCNT) begin
                prdata = tcnt_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fixed response and interrupt
    // ------------------------------------------------------------------------
    assign pready    = 1'b1;
    assign pslverr   = 1'b0;
    assign interrupt = |(tsr_q & tie_q);

endmodule

// File: tb/tb_timer8_apb_regs.sv
// ----------------------------------------------------------------------------
// tb_timer8_apb_regs
// Directed scenarios plus a randomized APB run against a behavioural model
// of the timer's register rules.
// ----------------------------------------------------------------------------
module tb_timer8_apb_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       interrupt;

    int errors = 0;
    int checks = 0;
    bit irq_check_on = 1'b0;

    // Behavioural model state
    logic [7:0] m_tdr  = 8'h00;
    logic [7:0] m_tcr  = 8'h00;
    logic [1:0] m_tsr  = 2'b00;
    logic [1:0] m_tie  = 2'b00;
    logic [7:0] m_tcnt = 8'h00;
    int         m_pre  = 0;

    timer8_apb_regs #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_tdr;
            8'h01:   return m_tcr;
            8'h02:   return {6'b0, m_tsr};
            8'h03:   return {6'b0, m_tie};
            8'h04:   return m_tcnt;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic m_irq();
        return ((m_tsr[0] && m_tie[0]) || (m_tsr[1] && m_tie[1]));
    endfunction

    // One clock of the timer rules, applied to the inputs present at the edge.
    task automatic model_update();
        logic [7:0] n_tdr, n_tcr, n_tcnt;
        logic [1:0] n_tsr, n_tie, set;
        int n_pre, div;
        bit wr;
        if (!rst_n) begin
            m_tdr = 0; m_tcr = 0; m_tsr = 0; m_tie = 0; m_tcnt = 0; m_pre = 0;
            return;
        end
        wr = psel && penable && pwrite;
        n_tdr = m_tdr; n_tcr = m_tcr; n_tie = m_tie; n_tcnt = m_tcnt;
        set = 2'b00;
        div = 1 << m_tcr[1:0];
        if (m_tcr[7]) begin
            n_tcnt = m_tdr;
            n_pre  = 0;
        end else if (m_tcr[4]) begin
            n_pre = (m_pre + 1) % 8;
            if (((m_pre + 1) % div) == 0) begin
                if (m_tcr[5]) begin
                    if (m_tcnt == 8'h00) set[1] = 1'b1;
                    n_tcnt = 8'(m_tcnt - 8'd1);
                end else begin
                    if (m_tcnt == 8'hFF) set[0] = 1'b1;
                    n_tcnt = 8'(m_tcnt + 8'd1);
                end
            end
        end else begin
            n_pre = 0;
        end
        if (wr && paddr == 8'h02) n_tsr = (m_tsr & ~pwdata[1:0]) | set;
        else                      n_tsr = m_tsr | set;
        if (wr) begin
            case (paddr)
                8'h00: n_tdr = pwdata;
                8'h01: begin n_tcr = pwdata & 8'hB3; n_pre = 0; end
                8'h03: n_tie = pwdata[1:0];
                default: ;
            endcase
        end
        m_tdr = n_tdr; m_tcr = n_tcr; m_tsr = n_tsr; m_tie = n_tie;
        m_tcnt = n_tcnt; m_pre = n_pre;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (irq_check_on) begin
            checks++;
            if (interrupt !== m_irq()) begin
                errors++;
                $display("FAIL irq_model: got %b expected %b at %0t", interrupt, m_irq(), $time);
            end
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        step();
        penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic [7:0] e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        step();
        penable = 1'b1;
        #1;
        d = prdata;
        e = m_read(a);
        step();
        psel = 1'b0; penable = 1'b0;
    endtask

    // Setup-phase read: prdata is valid without consuming a clock.
    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        #1;
        d = prdata;
        psel = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        for (int a = 0; a < 5; a++) begin
            peek(8'(a), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %02h expected 00", a, d); end
        end
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", interrupt); end
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b0) begin
            errors++; $display("FAIL resp_tie: got pready=%b pslverr=%b expected 1/0", pready, pslverr);
        end
    endtask

    task automatic test_rw_defaults();
        logic [7:0] d, e;
        // setup-only write cycles must not commit
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hAA;
        step(); step(); step();
        psel = 1'b0; pwrite = 1'b0;
        peek(8'h00, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL setup_no_write: got %02h expected 00", d); end
        apb_write(8'h00, 8'hFF);
        apb_read(8'h00, d, e);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL tdr_rw: got %02h expected FF", d); end
        apb_write(8'h01, 8'hFF);
        apb_read(8'h01, d, e);
        checks++;
        if (d !== 8'hB3) begin errors++; $display("FAIL tcr_rw: got %02h expected B3", d); end
        apb_write(8'h03, 8'hFF);
        apb_read(8'h03, d, e);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL tie_rw: got %02h expected 03", d); end
        apb_read(8'h04, d, e);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL tcnt_load: got %02h expected FF", d); end
        apb_write(8'h02, 8'hFF);
        apb_read(8'h02, d, e);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL tsr_after_load: got %02h expected 00", d); end
        apb_write(8'h01, 8'h00);
        apb_write(8'h03, 8'h00);
        apb_write(8'h00, 8'h00);
    endtask

    task automatic test_up_ovf();
        logic [7:0] d, exp;
        apb_write(8'h00, 8'hFD);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h12);
        for (int k = 1; k <= 12; k++) begin
            step();
            peek(8'h04, d);
            exp = 8'(253 + k / 4);
            checks++;
            if (d !== exp) begin errors++; $display("FAIL up_div4_cyc%0d: got %02h expected %02h", k, d, exp); end
        end
        peek(8'h02, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL ovf_flag: got %02h expected 01", d); end
        apb_write(8'h03, 8'h01);
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b expected 1", interrupt); end
        apb_write(8'h02, 8'h01);
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL ovf_irq_clear: got %b expected 0", interrupt); end
        apb_write(8'h01, 8'h00);
        apb_write(8'h03, 8'h00);
    endtask

    task automatic test_down_udf();
        logic [7:0] d;
        logic [7:0] seq [3];
        seq[0] = 8'h01; seq[1] = 8'h00; seq[2] = 8'hFF;
        apb_write(8'h00, 8'h02);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h30);
        for (int k = 0; k < 3; k++) begin
            step();
            peek(8'h04, d);
            checks++;
            if (d !== seq[k]) begin errors++; $display("FAIL down_div1_cyc%0d: got %02h expected %02h", k + 1, d, seq[k]); end
        end
        peek(8'h02, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL udf_flag: got %02h expected 02", d); end
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h03);
        peek(8'h02, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL udf_w1c: got %02h expected 00", d); end
    endtask

    task automatic test_pause();
        logic [7:0] d;
        apb_write(8'h00, 8'h0E);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h11);
        step(); step();
        peek(8'h04, d);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL pause_pre: got %02h expected 0F", d); end
        step();
        // setup edge takes the 0x10 tick, access edge lands on a non-tick cycle
        apb_write(8'h01, 8'h01);
        for (int k = 0; k < 20; k++) begin
            peek(8'h04, d);
            checks++;
            if (d !== 8'h10) begin errors++; $display("FAIL pause_hold%0d: got %02h expected 10", k, d); end
            step();
        end
        apb_write(8'h01, 8'h11);
        step();
        peek(8'h04, d);
        checks++;
        if (d !== 8'h10) begin errors++; $display("FAIL resume_1clk: got %02h expected 10", d); end
        step();
        peek(8'h04, d);
        checks++;
        if (d !== 8'h11) begin errors++; $display("FAIL resume_2clk: got %02h expected 11", d); end
        apb_write(8'h01, 8'h00);
    endtask

    task automatic test_collision();
        logic [7:0] d;
        apb_write(8'h00, 8'hFE);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        // access edge of this W1C coincides with FF -> 00
        apb_write(8'h02, 8'h01);
        peek(8'h04, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL collide_tcnt: got %02h expected 00", d); end
        peek(8'h02, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL collide_ovf: got %02h expected 01", d); end
        apb_write(8'h02, 8'h00);
        peek(8'h02, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL w0_keeps: got %02h expected 01", d); end
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h01);
        peek(8'h02, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL ovf_w1c: got %02h expected 00", d); end
    endtask

    task automatic test_reserved();
        logic [7:0] d, e, cnt;
        logic [7:0] a_list [4];
        a_list[0] = 8'h05; a_list[1] = 8'h06; a_list[2] = 8'h07; a_list[3] = 8'hFF;
        apb_write(8'h00, 8'h5A);
        apb_write(8'h03, 8'h02);
        peek(8'h04, cnt);
        apb_write(8'h05, 8'hFF);
        apb_write(8'h01, 8'h4C);
        for (int k = 0; k < 4; k++) begin
            apb_read(a_list[k], d, e);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL unmapped_%02h: got %02h expected 00", a_list[k], d); end
        end
        apb_read(8'h01, d, e);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL tcr_reserved: got %02h expected 00", d); end
        apb_read(8'h00, d, e);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL tdr_kept: got %02h expected 5A", d); end
        apb_read(8'h03, d, e);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL tie_kept: got %02h expected 02", d); end
        apb_read(8'h02, d, e);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL tsr_kept: got %02h expected 00", d); end
        apb_read(8'h04, d, e);
        checks++;
        if (d !== cnt) begin errors++; $display("FAIL tcnt_kept: got %02h expected %02h", d, cnt); end
        apb_write(8'h03, 8'h00);
    endtask

    task automatic test_reset_midcount();
        logic [7:0] d;
        apb_write(8'h00, 8'hFF);
        apb_write(8'h03, 8'h03);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        step();
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", interrupt); end
        // reset edge with a concurrent write access and a pending tick
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq_mid: got %b expected 0", interrupt); end
        for (int a = 0; a < 5; a++) begin
            peek(8'(a), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL midreset_reg%0d: got %02h expected 00", a, d); end
        end
        for (int k = 0; k < 5; k++) step();
        peek(8'h04, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL midreset_stopped: got %02h expected 00", d); end
    endtask

    task automatic test_random();
        logic [7:0] a, d, e;
        int r, n;
        irq_check_on = 1'b1;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                a = 8'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 8'h01 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
                if (a == 8'h00 && $urandom_range(0, 1) == 0) d = 8'hF0 | d;
                apb_write(a, d);
            end else if (r < 8) begin
                a = 8'($urandom_range(0, 7));
                apb_read(a, d, e);
                checks++;
                if (d !== e) begin errors++; $display("FAIL rand_read_%02h: got %02h expected %02h", a, d, e); end
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    step();
                    peek(8'h04, d);
                    checks++;
                    if (d !== m_tcnt) begin errors++; $display("FAIL rand_tcnt: got %02h expected %02h", d, m_tcnt); end
                end
            end
        end
        irq_check_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rw_defaults();
        test_up_ovf();
        test_down_udf();
        test_pause();
        test_collision();
        test_reserved();
        test_reset_midcount();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
